// File: rtl/seg_scan_pkg.sv
// Shared segment codes, scan FSM states and default digit count for the 7-seg scan decoder.
// Segment codes are active-high {g,f,e,d,c,b,a}; invert the board's active-low lines before matching.
package seg_scan_pkg;

    localparam int DIGITS_DEF = 8;

    localparam logic [6:0] SEG_0     = 7'h3F;
    localparam logic [6:0] SEG_1     = 7'h06;
    localparam logic [6:0] SEG_2     = 7'h5B;
    localparam logic [6:0] SEG_3     = 7'h4F;
    localparam logic [6:0] SEG_4     = 7'h66;
    localparam logic [6:0] SEG_5     = 7'h6D;
    localparam logic [6:0] SEG_6     = 7'h7D;
    localparam logic [6:0] SEG_7     = 7'h07;
    localparam logic [6:0] SEG_8     = 7'h7F;
    localparam logic [6:0] SEG_9     = 7'h6F;
    localparam logic [6:0] SEG_A     = 7'h77;
    localparam logic [6:0] SEG_B     = 7'h7C;
    localparam logic [6:0] SEG_C     = 7'h39;
    localparam logic [6:0] SEG_D     = 7'h5E;
    localparam logic [6:0] SEG_E     = 7'h79;
    localparam logic [6:0] SEG_F     = 7'h71;
    localparam logic [6:0] SEG_BLANK = 7'h00;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        HOLD
    } scan_state_t;

endpackage

// File: rtl/seg_hex_decode.sv
// Maps an active-high 7-segment pattern to a hex nibble, flagging blank and unknown patterns.
// Latency: combinational.
// Backpressure: none.
module seg_hex_decode
    import seg_scan_pkg::*;
(
    input  logic [6:0] seg,
    output logic [3:0] nibble,
    output logic       blank,
    output logic       invalid
);

    always_comb begin
        nibble  = 4'h0;
        blank   = 1'b0;
        invalid = 1'b0;
        case (seg)
            SEG_0:     nibble = 4'h0;
            SEG_1:     nibble = 4'h1;
            SEG_2:     nibble = 4'h2;
            SEG_3:     nibble = 4'h3;
            SEG_4:     nibble = 4'h4;
            SEG_5:     nibble = 4'h5;
            SEG_6:     nibble = 4'h6;
            SEG_7:     nibble = 4'h7;
            SEG_8:     nibble = 4'h8;
            SEG_9:     nibble = 4'h9;
            SEG_A:     nibble = 4'hA;
            SEG_B:     nibble = 4'hB;
            SEG_C:     nibble = 4'hC;
            SEG_D:     nibble = 4'hD;
            SEG_E:     nibble = 4'hE;
            SEG_F:     nibble = 4'hF;
            SEG_BLANK: blank  = 1'b1;
            default:   invalid = 1'b1;
        endcase
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// Rebuilds the value shown on a multiplexed active-low 7-seg scan; SEG_SCAN_CONFIRM_EN requires two equal frames before publishing.
// Latency: 2-cycle sync + SETTLE_CYCLES per digit; publish one cycle after the frame's last digit is captured.
// Backpressure: none; scan lines are sampled every cycle and outputs simply update.
module seg_scan_decoder
    import seg_scan_pkg::*;
#(
    parameter int DIGITS         = DIGITS_DEF,
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic                CLK,
    input  logic                RST_N,
    input  logic [7:0]          seg_data_i,
    input  logic [DIGITS-1:0]   seg_sel_i,
    output logic [4*DIGITS-1:0] value_o,
    output logic [DIGITS-1:0]   blank_o,
    output logic [DIGITS-1:0]   dp_o,
    output logic                frame_valid_o,
    output logic                frame_err_o,
    output logic                stale_o
);

    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [DIGITS-1:0]   sel_s1, sel_s2, sel_prev;
    logic [7:0]          dat_s1, dat_s2, dat_prev;
    logic [DIGITS-1:0]   sel_low, cap_mask, seen;
    logic                sel_single, sel_multi, same;
    scan_state_t         state, state_nxt;
    logic [CW-1:0]       settle_cnt;
    logic                cnt_load, cnt_inc, capture;
    logic [3:0]          dec_nib;
    logic                dec_blank, dec_invalid;
    logic [4*DIGITS-1:0] sh_val;
    logic [DIGITS-1:0]   sh_blank, sh_dp;
    logic                err_pending;
    logic [TW-1:0]       to_cnt;
    logic                to_hit, frame_done, clr, publish;

    // Idle lines are high, so the synchroniser resets to the inter-digit gap.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sel_s1   <= '1;
            sel_s2   <= '1;
            sel_prev <= '1;
            dat_s1   <= '1;
            dat_s2   <= '1;
            dat_prev <= '1;
        end else begin
            sel_s1   <= seg_sel_i;
            sel_s2   <= sel_s1;
            sel_prev <= sel_s2;
            dat_s1   <= seg_data_i;
            dat_s2   <= dat_s1;
            dat_prev <= dat_s2;
        end
    end

    assign sel_low    = ~sel_s2;
    assign sel_single = $onehot(sel_low);
    assign sel_multi  = (sel_low != '0) && !sel_single;
    assign same       = (sel_s2 == sel_prev) && (dat_s2 == dat_prev);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cnt_load  = 1'b0;
        cnt_inc   = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (sel_single) begin
                    cnt_load  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (!sel_single) begin
                    state_nxt = IDLE;
                end else if (!same) begin
                    cnt_load = 1'b1;
                end else if (settle_cnt >= CW'(SETTLE_CYCLES - 1)) begin
                    capture   = 1'b1;
                    state_nxt = HOLD;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            HOLD: begin
                if (!sel_single) begin
                    state_nxt = IDLE;
                end else if (sel_s2 != sel_prev) begin
                    cnt_load  = 1'b1;
                    state_nxt = SETTLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // The sample that starts a settle window counts as the first identical one.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)        settle_cnt <= '0;
        else if (cnt_load) settle_cnt <= CW'(1);
        else if (cnt_inc)  settle_cnt <= settle_cnt + 1'b1;
    end

    seg_hex_decode u_hex (
        .seg     (~dat_s2[6:0]),
        .nibble  (dec_nib),
        .blank   (dec_blank),
        .invalid (dec_invalid)
    );

    assign cap_mask   = capture ? sel_low : '0;
    assign frame_done = &seen;
    assign to_hit     = !capture && (to_cnt == TW'(TIMEOUT_CYCLES - 1));
    assign clr        = frame_done | to_hit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            sh_val      <= '0;
            sh_blank    <= '0;
            sh_dp       <= '0;
            seen        <= '0;
            err_pending <= 1'b0;
            to_cnt      <= '0;
        end else begin
            for (int i = 0; i < DIGITS; i++) begin
                if (cap_mask[i]) begin
                    sh_val[4*i +: 4] <= dec_nib;
                    sh_blank[i]      <= dec_blank;
                    sh_dp[i]         <= ~dat_s2[7];
                end
            end
            seen        <= (clr ? '0 : seen) | cap_mask;
            err_pending <= (clr ? 1'b0 : err_pending) | sel_multi | (capture & dec_invalid);
            if (capture)
                to_cnt <= '0;
            else if (to_cnt != TW'(TIMEOUT_CYCLES))
                to_cnt <= to_cnt + 1'b1;
        end
    end

`ifdef SEG_SCAN_CONFIRM_EN
    logic [4*DIGITS-1:0] cand_val;
    logic [DIGITS-1:0]   cand_blank, cand_dp;
    logic                cand_err, cand_vld;

    assign publish = frame_done && cand_vld && (cand_val == sh_val) && (cand_blank == sh_blank)
                     && (cand_dp == sh_dp) && (cand_err == err_pending);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            cand_val   <= '0;
            cand_blank <= '0;
            cand_dp    <= '0;
            cand_err   <= 1'b0;
            cand_vld   <= 1'b0;
        end else if (to_hit) begin
            cand_vld <= 1'b0;
        end else if (frame_done) begin
            cand_val   <= sh_val;
            cand_blank <= sh_blank;
            cand_dp    <= sh_dp;
            cand_err   <= err_pending;
            cand_vld   <= 1'b1;
        end
    end
`else
    assign publish = frame_done;
`endif

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            value_o       <= '0;
            blank_o       <= '0;
            dp_o          <= '0;
            frame_valid_o <= 1'b0;
            frame_err_o   <= 1'b0;
            stale_o       <= 1'b0;
        end else begin
            frame_valid_o <= publish;
            if (publish) begin
                value_o     <= sh_val;
                blank_o     <= sh_blank;
                dp_o        <= sh_dp;
                frame_err_o <= err_pending;
                stale_o     <= 1'b0;
            end else if (to_hit) begin
                stale_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: scan vectors feed a digit-level frame model whose
// expected frames are queued at drive time and popped on every frame_valid_o pulse.
module tb_seg_scan_decoder;

    localparam int DIGITS = 8;
    localparam int SETTLE = 16;
    localparam int TO     = 2000;
    localparam int HOLD   = 40;

    typedef struct packed {
        logic [31:0] val;
        logic [7:0]  blank;
        logic [7:0]  dp;
        logic        err;
    } frame_t;

    typedef struct {
        logic [31:0] val;
        logic [7:0]  blank;
        logic [7:0]  dp;
        logic [7:0]  bad;
        logic [31:0] exp_val;
    } vec_t;

    logic              CLK = 1'b0;
    logic              RST_N = 1'b0;
    logic [7:0]        seg_data_i = 8'hFF;
    logic [DIGITS-1:0] seg_sel_i = '1;
    logic [31:0]       value_o;
    logic [7:0]        blank_o, dp_o;
    logic              frame_valid_o, frame_err_o, stale_o;

    int     checks = 0;
    int     failures = 0;
    int     n_pushed = 0;
    int     n_pulses = 0;
    frame_t exp_q[$];
    frame_t last_pub = '0;
    logic [31:0] m_val = '0;
    logic [7:0]  m_blank = '0, m_dp = '0, m_seen = '0;
    logic        m_err = 1'b0, m_stale = 1'b0;
`ifdef SEG_SCAN_CONFIRM_EN
    frame_t cand = '0;
    logic   cand_vld = 1'b0;
`endif

    always #5 CLK = ~CLK;

    seg_scan_decoder #(
        .DIGITS         (DIGITS),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .CLK           (CLK),
        .RST_N         (RST_N),
        .seg_data_i    (seg_data_i),
        .seg_sel_i     (seg_sel_i),
        .value_o       (value_o),
        .blank_o       (blank_o),
        .dp_o          (dp_o),
        .frame_valid_o (frame_valid_o),
        .frame_err_o   (frame_err_o),
        .stale_o       (stale_o)
    );

    function automatic logic [6:0] seg_code(input logic [3:0] n);
        case (n)
            4'h0: return 7'h3F;  4'h1: return 7'h06;  4'h2: return 7'h5B;  4'h3: return 7'h4F;
            4'h4: return 7'h66;  4'h5: return 7'h6D;  4'h6: return 7'h7D;  4'h7: return 7'h07;
            4'h8: return 7'h7F;  4'h9: return 7'h6F;  4'hA: return 7'h77;  4'hB: return 7'h7C;
            4'hC: return 7'h39;  4'hD: return 7'h5E;  4'hE: return 7'h79;  default: return 7'h71;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic publish_exp(input frame_t f);
        exp_q.push_back(f);
        last_pub = f;
        m_stale  = 1'b0;
        n_pushed++;
    endtask

    task automatic complete_frame();
        frame_t f;
        f.val   = m_val;
        f.blank = m_blank;
        f.dp    = m_dp;
        f.err   = m_err;
        m_seen  = '0;
        m_err   = 1'b0;
`ifdef SEG_SCAN_CONFIRM_EN
        if (cand_vld && cand == f) publish_exp(f);
        cand     = f;
        cand_vld = 1'b1;
`else
        publish_exp(f);
`endif
    endtask

    task automatic model_clear();
        m_seen = '0;
        m_err  = 1'b0;
`ifdef SEG_SCAN_CONFIRM_EN
        cand_vld = 1'b0;
`endif
    endtask

    // Two-cycle all-high gap, then digit i held for 'hold' cycles.
    task automatic drive_digit(input int i, input logic [7:0] seg, input int hold,
                               input logic [3:0] nib, input logic blk, input logic dp, input logic err);
        seg_sel_i  = '1;
        seg_data_i = 8'hFF;
        tick(2);
        if (hold >= SETTLE + 4) begin
            m_val[4*i +: 4] = nib;
            m_blank[i]      = blk;
            m_dp[i]         = dp;
            m_err           = m_err | err;
            m_seen[i]       = 1'b1;
            if (&m_seen) complete_frame();
        end
        seg_sel_i  = ~(8'h01 << i);
        seg_data_i = seg;
        tick(hold);
    endtask

    task automatic drive_hex(input int i, input logic [3:0] nib, input logic dp);
        drive_digit(i, {~dp, ~seg_code(nib)}, HOLD, nib, 1'b0, dp, 1'b0);
    endtask

    task automatic scan_vec(input vec_t v, input int short_dig);
        for (int i = 0; i < DIGITS; i++) begin
            logic [7:0] seg;
            if (v.blank[i])    seg = 8'hFF;
            else if (v.bad[i]) seg = ~8'h49;
            else               seg = {1'b1, ~seg_code(v.val[4*i +: 4])};
            seg[7] = ~v.dp[i];
            drive_digit(i, seg, (i == short_dig) ? 10 : HOLD, v.exp_val[4*i +: 4],
                        v.blank[i], v.dp[i], v.bad[i]);
        end
    endtask

    always @(negedge CLK) begin
        if (RST_N && frame_valid_o) begin
            n_pulses++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse actual=pulse value=%h required=no pulse", value_o);
            end else begin
                frame_t f;
                f = exp_q.pop_front();
                chk("value", value_o, f.val);
                chk("blank", 32'(blank_o), 32'(f.blank));
                chk("dp", 32'(dp_o), 32'(f.dp));
                chk("frame_err", 32'(frame_err_o), 32'(f.err));
                chk("stale_on_pulse", 32'(stale_o), 32'(1'b0));
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog actual=still running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        vec_t v;
        vecs[0] = '{32'h0000_000F, 8'h00, 8'h00, 8'h00, 32'h0000_000F};
        vecs[1] = '{32'h1234_5678, 8'h00, 8'hA5, 8'h00, 32'h1234_5678};
        vecs[2] = '{32'h89AB_CDEF, 8'h20, 8'h00, 8'h00, 32'h890B_CDEF};
        vecs[3] = '{32'h7654_3210, 8'h00, 8'h00, 8'h04, 32'h7654_3010};
        vecs[4] = '{32'h7654_3210, 8'h00, 8'h00, 8'h00, 32'h7654_3210};
        vecs[5] = '{32'hFEDC_BA98, 8'h00, 8'hFF, 8'h00, 32'hFEDC_BA98};

        tick(3);
        chk("rst_value", value_o, 32'h0);
        chk("rst_blank", 32'(blank_o), 32'h0);
        chk("rst_dp", 32'(dp_o), 32'h0);
        chk("rst_valid", 32'(frame_valid_o), 32'h0);
        chk("rst_err", 32'(frame_err_o), 32'h0);
        chk("rst_stale", 32'(stale_o), 32'h0);
        RST_N = 1'b1;
        tick(4);

        for (int k = 0; k < 6; k++) scan_vec(vecs[k], -1);

        // Digit 3 too short to settle; the next scan completes a frame mixing old and new digits.
        v = '{32'h0000_000F, 8'h00, 8'h00, 8'h00, 32'h0000_000F};
        scan_vec(v, 3);
        v = '{32'hCAFE_0123, 8'h00, 8'h00, 8'h00, 32'hCAFE_0123};
        scan_vec(v, -1);

        seg_sel_i  = '1;
        seg_data_i = 8'hFF;
        tick(TO - 100);
        chk("stale_before_timeout", 32'(stale_o), 32'(m_stale));
        tick(200);
        m_stale = 1'b1;
        model_clear();
        chk("stale_after_timeout", 32'(stale_o), 32'(m_stale));
        chk("value_hold_stale", value_o, last_pub.val);
        v = '{32'h0000_001C, 8'h00, 8'h00, 8'h00, 32'h0000_001C};
        scan_vec(v, -1);
        tick(4);
        chk("stale_after_scan", 32'(stale_o), 32'(m_stale));

        // Two selects low mid-frame.
        for (int i = 0; i < 4; i++) drive_hex(i, 4'h5, 1'b0);
        seg_sel_i  = ~8'h03;
        seg_data_i = 8'hC0;
        m_err      = 1'b1;
        tick(50);
        for (int i = 4; i < 8; i++) drive_hex(i, 4'h5, 1'b0);
        v = '{32'h5555_5555, 8'h00, 8'h0F, 8'h00, 32'h5555_5555};
        scan_vec(v, -1);
        scan_vec(v, -1);

        // Reset in the middle of a frame.
        for (int i = 0; i < 4; i++) drive_hex(i, 4'(i + 1), 1'b0);
        RST_N = 1'b0;
        #2;
        chk("midrst_value", value_o, 32'h0);
        chk("midrst_blank", 32'(blank_o), 32'h0);
        chk("midrst_dp", 32'(dp_o), 32'h0);
        chk("midrst_err", 32'(frame_err_o), 32'h0);
        chk("midrst_stale", 32'(stale_o), 32'h0);
        chk("midrst_queue", 32'(exp_q.size()), 32'h0);
        model_clear();
        m_stale  = 1'b0;
        last_pub = '0;
        tick(3);
        RST_N = 1'b1;
        tick(2);
        for (int i = 4; i < 8; i++) drive_hex(i, 4'(i + 1), 1'b0);
        chk("no_pulse_half_frame", 32'(n_pulses), 32'(n_pushed));
        for (int i = 0; i < 4; i++) drive_hex(i, 4'(i + 1), 1'b0);

        v = '{32'h0000_0015, 8'h00, 8'h00, 8'h00, 32'h0000_0015};
        scan_vec(v, -1);
        v = '{32'h0000_0014, 8'h00, 8'h00, 8'h00, 32'h0000_0014};
        scan_vec(v, -1);
        scan_vec(v, -1);
        tick(4);
        chk("final_value", value_o, last_pub.val);

        seg_sel_i  = '1;
        seg_data_i = 8'hFF;
        tick(20);
        chk("queue_empty", 32'(exp_q.size()), 32'h0);
        chk("pulse_count", 32'(n_pulses), 32'(n_pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
